dsp_mac_ctrl: RTL and testbench
===============================

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 SHALL have parameter DSP_LAT, default 3, meaning edges from operands on dsp_a/dsp_b to the final value on dsp_p (A1REG=1, MREG=1, PREG=1, OPMODEREG=1).
REQ-002 SHALL have ports as listed, clock and reset first:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request, sampled in IDLE only.
- len  in  8  term count, captured on start.
- sub  in  1  1 = subtract terms from bias; captured on start.
- bias  in  48  initial accumulator value; captured on start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid and in_ready are both high.
- in_a  in  18  multiplicand.
- in_b  in  18  multiplier.
- dsp_a  out  18  to DSP A port.
- dsp_b  out  18  to DSP B port.
- dsp_c  out  48  to DSP C port.
- dsp_opmode  out  8  to DSP OPMODE port.
- dsp_p  in  48  from DSP P port.
- dsp_carryout  in  1  from DSP CARRYOUT port.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid and res_ready are both high.
- res_data  out  48  accumulated result.
- res_carry  out  1  DSP carry-out for the final term.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DRAIN -> OUT -> IDLE.
REQ-004 IDLE: start=1 SHALL capture len, sub and bias; go to RUN; clear term counter cnt.
REQ-005 RUN: in_ready SHALL equal (cnt < len); each handshake SHALL increment cnt; cnt==len SHALL go to DRAIN; len=0 SHALL go to DRAIN on the first RUN cycle.
REQ-006 Accepted in_a/in_b SHALL appear on dsp_a/dsp_b from the edge after the handshake, and hold until the next handshake.
REQ-007 dsp_c SHALL hold the captured bias for the whole job.
REQ-008 dsp_opmode SHALL present each term's opmode one edge after that term's dsp_a/dsp_b update.
- First term: 0x0D (X=M, Z=C, add); 0x8D if sub.
- Later terms: 0x09 (X=M, Z=P); 0x89 if sub.
REQ-009 A cycle with no term in the opmode slot SHALL drive 0x08 (X=0, Z=P), so P holds.
- Applies to stalls, DRAIN, OUT and IDLE.
REQ-010 len=0 SHALL issue one opmode 0x0C (X=0, Z=C) in the first-term slot, so the result equals bias.
REQ-011 opmode bit 5 SHALL always be 0 (carry-in 0) and bit 6 SHALL be 0 (pre-adder add).
- Bit 4 SHALL be 0 so B bypasses the pre-adder.
REQ-012 DRAIN SHALL count DSP_LAT edges from the last dsp_a/dsp_b update (or the 0x0C slot).
- Then capture dsp_p into res_data and dsp_carryout into res_carry, and go to OUT.
- With DSP_LAT=3, res_valid SHALL rise 4 edges after the last input handshake edge.
REQ-013 OUT: res_valid=1; res_data/res_carry SHALL hold stable until res_ready=1, then return to IDLE on that edge.
REQ-014 start SHALL be ignored outside IDLE; in_ready SHALL be 0 outside RUN.
REQ-015 Arithmetic is the DSP's 48-bit wrap; the block SHALL NOT saturate or sign-extend beyond forwarding.

Reset
REQ-016 rst=1 SHALL force IDLE asynchronously, including mid-job.
- Zero outputs: in_ready, res_valid, res_data, res_carry, busy, dsp_a, dsp_b, dsp_c.
- dsp_opmode SHALL be 0x08.
- The in-flight job SHALL be discarded, with no res_valid after release.
REQ-017 After rst deasserts, the first start SHALL behave as from power-up.

Verification
REQ-018 bias=100, len=3, pairs (2,5), (3,6), (4,7) back-to-back, DSP_LAT=3 with a DSP model -> opmodes 0x0D, 0x09, 0x09; res_data=156; res_valid 4 edges after the last handshake.
REQ-019 sub=1, bias=1000, len=2, pairs (10,10), (5,4) -> opmodes 0x8D, 0x89; res_data=880.
REQ-020 Same job as REQ-018 with in_valid low for 2 cycles between terms -> 0x08 in the gap slots; res_data=156.
REQ-021 len=0, bias=100 -> single opmode 0x0C; res_data=100; in_ready never high.
REQ-022 res_ready low for 5 cycles in OUT, with start pulsed during OUT -> res_data stable, start ignored; IDLE after the res_ready handshake.
REQ-023 rst pulsed after the 2nd term of a len=3 job -> all outputs at reset values immediately and no res_valid; a new job bias=0, (1,1) -> res_data=1.

Source files
------------

// File: rtl/dsp_mac_ctrl.sv
// Sequencer for a pipelined DSP48-style MAC slice.
// Each job loads a bias into C and streams len operand pairs into A/B.
// It issues one OPMODE per term, waits out the DSP pipeline, and then
// presents P (with carry-out) as a single result beat.
//
// state | meaning
// IDLE  | waiting for start; opmode parked at Z=P, X=0
// RUN   | accepting operand pairs until len terms are issued
// DRAIN | letting the last term ripple through the DSP pipeline
// OUT   | result held on res_data until res_ready
module dsp_mac_ctrl #(
    parameter int DSP_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        sub,
    input  logic [47:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_data,
    output logic        res_carry,
    output logic        busy
);

    localparam int DCW = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);
    localparam logic [7:0] OP_HOLD = 8'h08;
    localparam logic [7:0] OP_BIAS = 8'h0C;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t         state, state_nxt;
    logic [7:0]     len_r;
    logic [7:0]     cnt;
    logic           sub_r;
    logic [DCW-1:0] dcnt;
    logic           pend;
    logic           pend_first;
    logic           pend_zero;
    logic           hs;
    logic           start_job;
    logic           zero_slot;
    logic           cap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        hs        = 1'b0;
        start_job = 1'b0;
        zero_slot = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_job = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = (cnt < len_r);
                hs       = in_valid && in_ready;
                if (len_r == 8'd0) begin
                    // empty job still needs one slot that loads C into P
                    zero_slot = 1'b1;
                    state_nxt = DRAIN;
                end else if (hs && (({1'b0, cnt} + 9'd1) == {1'b0, len_r})) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt == '0) begin
                    cap       = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job capture, operand forwarding, opmode slotting, drain timer, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= '0;
            sub_r      <= 1'b0;
            cnt        <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_c      <= '0;
            dsp_opmode <= OP_HOLD;
            pend       <= 1'b0;
            pend_first <= 1'b0;
            pend_zero  <= 1'b0;
            dcnt       <= '0;
            res_data   <= '0;
            res_carry  <= 1'b0;
        end else begin
            if (start_job) begin
                len_r <= len;
                sub_r <= sub;
                dsp_c <= bias;
                cnt   <= '0;
            end
            if (hs) begin
                dsp_a <= in_a;
                dsp_b <= in_b;
                cnt   <= cnt + 8'd1;
            end
            // opmode trails operands by one edge to line up with the MREG stage
            pend       <= hs || zero_slot;
            pend_first <= (cnt == 8'd0);
            pend_zero  <= zero_slot;
            if (pend_zero)  dsp_opmode <= OP_BIAS;
            else if (pend)  dsp_opmode <= {sub_r, 3'b000, 1'b1, pend_first, 2'b01};
            else            dsp_opmode <= OP_HOLD;
            if (hs || zero_slot)
                dcnt <= DCW'(DSP_LAT);
            else if (state == DRAIN && dcnt != '0)
                dcnt <= dcnt - DCW'(1);
            if (cap) begin
                res_data  <= dsp_p;
                res_carry <= dsp_carryout;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Directed bench for dsp_mac_ctrl with a behavioural DSP slice (A1/M/P/OPMODE regs).
module tb_dsp_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        sub = 1'b0;
    logic [47:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        dsp_carryout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic        res_carry;
    logic        busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dsp_mac_ctrl #(.DSP_LAT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .busy(busy)
    );

    // behavioural DSP slice: A1REG, MREG, OPMODEREG, PREG
    logic [17:0]        a1, b1;
    logic [47:0]        m_r, p_r, x_v, z_v;
    logic [7:0]         op_r;
    logic               co_r;
    logic signed [35:0] prod;
    logic [48:0]        sum;

    always_comb begin
        prod = $signed(a1) * $signed(b1);
        x_v  = (op_r[1:0] == 2'b01) ? m_r : 48'd0;
        case (op_r[3:2])
            2'b10:   z_v = p_r;
            2'b11:   z_v = dsp_c;
            default: z_v = 48'd0;
        endcase
        if (op_r[7]) sum = {1'b0, z_v} - {1'b0, x_v};
        else         sum = {1'b0, z_v} + {1'b0, x_v};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a1 <= '0; b1 <= '0; m_r <= '0; p_r <= '0; op_r <= 8'h08; co_r <= 1'b0;
        end else begin
            a1   <= dsp_a;
            b1   <= dsp_b;
            m_r  <= {{12{prod[35]}}, prod};
            op_r <= dsp_opmode;
            p_r  <= sum[47:0];
            co_r <= sum[48];
        end
    end
    assign dsp_p = p_r;
    assign dsp_carryout = co_r;

    always @(posedge clk) cyc <= cyc + 1;

    // opmode trace and in_ready monitor while a job is being logged
    logic [7:0] op_log[$];
    bit         log_en = 0;
    bit         saw_ready = 0;
    always @(negedge clk) begin
        if (log_en) begin
            op_log.push_back(dsp_opmode);
            if (in_ready) saw_ready = 1;
        end
    end

    logic [17:0] ta[4];
    logic [17:0] tb2[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one operand pair and wait for its handshake edge; returns with cyc at that edge
    task automatic do_term(input logic [17:0] a, input logic [17:0] b, output int hs_cyc);
        bit ok;
        int t;
        in_valid = 1'b1; in_a = a; in_b = b; t = 0;
        forever begin
            ok = in_ready;
            @(negedge clk);
            if (ok) break;
            t++;
            if (t > 50) begin chk("hs_timeout", 0, 1); break; end
        end
        hs_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [47:0] b_v, input int n, input logic s_v,
                           input int gap, input int hold,
                           output logic [47:0] rd, output logic rc, output int lat);
        int last_hs;
        int t;
        op_log.delete(); saw_ready = 0; log_en = 1;
        bias = b_v; len = 8'(n); sub = s_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_hs = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            do_term(ta[i], tb2[i], last_hs);
        end
        t = 0;
        while (!res_valid && t < 60) begin @(negedge clk); t++; end
        if (!res_valid) chk("res_timeout", 0, 1);
        lat = cyc - last_hs;
        rd = res_data; rc = res_carry;
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, rd);
            @(negedge clk);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        log_en = 0;
    endtask

    task automatic check_ops(input int n, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input int gaps_exp);
        logic [7:0] exp_ops[3];
        int nz[$];
        int g;
        exp_ops[0] = e0; exp_ops[1] = e1; exp_ops[2] = e2;
        foreach (op_log[i]) if (op_log[i] != 8'h08) nz.push_back(i);
        chk("op_count", nz.size(), n);
        for (int i = 0; i < n && i < nz.size(); i++) chk("opmode", op_log[nz[i]], exp_ops[i]);
        if (gaps_exp >= 0 && nz.size() > 0) begin
            g = 0;
            for (int i = nz[0]; i <= nz[nz.size()-1]; i++) if (op_log[i] == 8'h08) g++;
            chk("gap_slots", g, gaps_exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_carry"}, res_carry, 0);
        chk({tag, "_dsp_a"}, dsp_a, 0);
        chk({tag, "_dsp_b"}, dsp_b, 0);
        chk({tag, "_dsp_c"}, dsp_c, 0);
        chk({tag, "_opmode"}, dsp_opmode, 8'h08);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] rd;
        logic        rc;
        int          lat;
        int          hs_cyc;
        bit          seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // 100 + 2*5 + 3*6 + 4*7 = 156
        ta[0] = 18'd2; tb2[0] = 18'd5;
        ta[1] = 18'd3; tb2[1] = 18'd6;
        ta[2] = 18'd4; tb2[2] = 18'd7;
        run_job(48'd100, 3, 1'b0, 0, 0, rd, rc, lat);
        check_ops(3, 8'h0D, 8'h09, 8'h09, 0);
        chk("t1_data", rd, 48'd156);
        chk("t1_carry", rc, 0);
        chk("t1_latency", lat, 4);
        chk("t1_dsp_c", dsp_c, 48'd100);
        chk("t1_idle", busy, 0);

        // 1000 - 100 - 20 = 880
        ta[0] = 18'd10; tb2[0] = 18'd10;
        ta[1] = 18'd5;  tb2[1] = 18'd4;
        run_job(48'd1000, 2, 1'b1, 0, 0, rd, rc, lat);
        check_ops(2, 8'h8D, 8'h89, 8'h00, 0);
        chk("t2_data", rd, 48'd880);

        // stalls of 2 cycles between terms: 4 idle slots between the 3 term opmodes
        ta[0] = 18'd2; tb2[0] = 18'd5;
        ta[1] = 18'd3; tb2[1] = 18'd6;
        ta[2] = 18'd4; tb2[2] = 18'd7;
        run_job(48'd100, 3, 1'b0, 2, 0, rd, rc, lat);
        check_ops(3, 8'h0D, 8'h09, 8'h09, 4);
        chk("t3_data", rd, 48'd156);
        chk("t3_latency", lat, 4);

        // empty job returns the bias
        run_job(48'd100, 0, 1'b0, 0, 0, rd, rc, lat);
        check_ops(1, 8'h0C, 8'h00, 8'h00, -1);
        chk("t4_data", rd, 48'd100);
        chk("t4_no_ready", saw_ready, 0);

        // result held 5 cycles with start pulsed in OUT
        run_job(48'd100, 3, 1'b0, 0, 5, rd, rc, lat);
        chk("t5_data", rd, 48'd156);
        chk("t5_idle", busy, 0);
        chk("t5_no_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("t5_start_ignored", busy, 0);

        // 48-bit wrap: all-ones + 1 = 0 with carry-out
        ta[0] = 18'd1; tb2[0] = 18'd1;
        run_job(48'hFFFF_FFFF_FFFF, 1, 1'b0, 0, 0, rd, rc, lat);
        chk("t6_data", rd, 48'd0);
        chk("t6_carry", rc, 1);

        // reset in the middle of a 3-term job
        bias = 48'd100; len = 8'd3; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_term(18'd2, 18'd5, hs_cyc);
        do_term(18'd3, 18'd6, hs_cyc);
        chk("t7_mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1;
        end
        chk("t7_no_result", seen, 0);

        ta[0] = 18'd1; tb2[0] = 18'd1;
        run_job(48'd0, 1, 1'b0, 0, 0, rd, rc, lat);
        check_ops(1, 8'h0D, 8'h00, 8'h00, -1);
        chk("t7_new_data", rd, 48'd1);
        chk("t7_latency", lat, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
